// File: rtl/cpu.sv
// Single-cycle 8-bit core: 32-bit PC, 8x8 register file, 8-bit ALU and decoder.
// Instruction memory is external; the core presents PC and consumes INSTRUCTION.

// Register file: two combinational read ports, one write port, synchronous clear.
module cpu_regfile (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] rt_addr,
    input  logic [2:0] rs_addr,
    output logic [7:0] rt_data,
    output logic [7:0] rs_data,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data
);

    logic [7:0] registers [0:7];

    // Clear every register on reset, otherwise perform the single write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                registers[i] <= 8'h00;
            end
        end else if (wr_en) begin
            registers[wr_addr] <= wr_data;
        end
    end

    assign rt_data = registers[rt_addr];
    assign rs_data = registers[rs_addr];

endmodule

module cpu (
    input  logic [31:0] INSTRUCTION,
    input  logic        RESET,
    input  logic        CLK,
    output logic [31:0] PC
);

    typedef enum logic [7:0] {
        OP_LOADI = 8'h00,
        OP_MOV   = 8'h01,
        OP_ADD   = 8'h02,
        OP_SUB   = 8'h03,
        OP_AND   = 8'h04,
        OP_OR    = 8'h05,
        OP_J     = 8'h06,
        OP_BEQ   = 8'h07
    } opcode_e;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [7:0]  opcode;
    logic [7:0]  dest_field;
    logic [2:0]  rd_idx;
    logic [2:0]  rt_idx;
    logic [2:0]  rs_idx;
    logic [7:0]  imm;
    logic [7:0]  rt_val;
    logic [7:0]  rs_val;
    logic [7:0]  sub_result;
    logic        alu_zero;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic [31:0] pc_plus4;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic        unused_src1_bits;

    assign opcode     = INSTRUCTION[31:24];
    assign dest_field = INSTRUCTION[23:16];
    assign rd_idx     = INSTRUCTION[18:16];
    assign rt_idx     = INSTRUCTION[10:8];
    assign rs_idx     = INSTRUCTION[2:0];
    assign imm        = INSTRUCTION[7:0];

    // Upper register-index bits of SRC1 carry no meaning.
    assign unused_src1_bits = &{1'b0, INSTRUCTION[15:11]};

    cpu_regfile registerFile (
        .clk     (CLK),
        .rst_n   (RESET),
        .rt_addr (rt_idx),
        .rs_addr (rs_idx),
        .rt_data (rt_val),
        .rs_data (rs_val),
        .wr_en   (wr_en),
        .wr_addr (rd_idx),
        .wr_data (wr_data)
    );

    // Subtraction is done as two's-complement addition; its zero flag decides BEQ.
    assign sub_result = rt_val + (~rs_val + 8'd1);
    assign alu_zero   = (sub_result == 8'h00);

    // PC-relative target: signed word offset measured from the next instruction.
    assign pc_plus4      = pc_q + 32'd4;
    assign branch_offset = {{22{dest_field[7]}}, dest_field, 2'b00};
    assign branch_target = pc_plus4 + branch_offset;

    // Decode: select the ALU result, the write enable and the next PC.
    always_comb begin
        wr_data = 8'h00;
        wr_en   = 1'b0;
        pc_d    = pc_plus4;
        case (opcode)
            OP_LOADI: begin wr_data = imm;             wr_en = 1'b1; end
            OP_MOV:   begin wr_data = rs_val;          wr_en = 1'b1; end
            OP_ADD:   begin wr_data = rt_val + rs_val; wr_en = 1'b1; end
            OP_SUB:   begin wr_data = sub_result;      wr_en = 1'b1; end
            OP_AND:   begin wr_data = rt_val & rs_val; wr_en = 1'b1; end
            OP_OR:    begin wr_data = rt_val | rs_val; wr_en = 1'b1; end
            OP_J:     pc_d = branch_target;
            OP_BEQ:   pc_d = alu_zero ? branch_target : pc_plus4;
            default:  pc_d = pc_plus4;
        endcase
    end

    // Program counter register with synchronous active-low clear.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pc_q <= 32'h0000_0000;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC = pc_q;

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: directed program scenarios plus random instructions
// compared against an instruction-level model of the ISA.
module tb_cpu;

    logic        clk;
    logic        reset_n;
    logic [31:0] instruction;
    logic [31:0] pc;

    int checks;
    int errors;

    logic [7:0]  m_regs [8];
    logic [31:0] m_pc;

    cpu dut (
        .INSTRUCTION (instruction),
        .RESET       (reset_n),
        .CLK         (clk),
        .PC          (pc)
    );

    // 8-unit clock period.
    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Architectural model: executes one instruction from the ISA definition.
    task automatic model_exec(input logic [31:0] ins);
        int op;
        int rd;
        int rt;
        int rs;
        int off;
        int a;
        int b;
        op  = int'(ins[31:24]);
        rd  = int'(ins[18:16]);
        rt  = int'(ins[10:8]);
        rs  = int'(ins[2:0]);
        off = int'($signed(ins[23:16]));
        a   = int'(m_regs[rt]);
        b   = int'(m_regs[rs]);
        case (op)
            0: m_regs[rd] = ins[7:0];
            1: m_regs[rd] = m_regs[rs];
            2: m_regs[rd] = 8'((a + b) % 256);
            3: m_regs[rd] = 8'((a - b + 256) % 256);
            4: m_regs[rd] = 8'(a & b);
            5: m_regs[rd] = 8'(a | b);
            default: ;
        endcase
        if (op == 6 || (op == 7 && a == b)) begin
            m_pc = m_pc + 32'(4 + off * 4);
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    endtask

    // Drive one instruction for one cycle and advance the model.
    task automatic step(input logic [31:0] ins);
        @(negedge clk);
        reset_n     = 1'b1;
        instruction = ins;
        @(posedge clk);
        model_exec(ins);
        #1;
    endtask

    // Synchronous reset across one rising edge, released right after.
    task automatic do_reset();
        @(negedge clk);
        reset_n     = 1'b0;
        instruction = 32'h0000_0000;
        @(posedge clk);
        model_reset();
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n     = 1'b0;
        instruction = 32'h0003_00AA;
        @(posedge clk);
        model_reset();
        #1;
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_pc: got %08h expected 00000000", pc);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.registerFile.registers[i] !== 8'h00) begin
                errors++;
                $display("[TB] FAIL reset_r%0d: got %02h expected 00", i, dut.registerFile.registers[i]);
            end
        end
        step(32'hFF00_0000);
        checks++;
        if (pc !== 32'd4) begin
            errors++;
            $display("[TB] FAIL reset_release_pc: got %08h expected 00000004", pc);
        end
    endtask

    task automatic test_load_add();
        logic [31:0] prog [3];
        logic [31:0] exp_pc [3];
        prog   = '{32'h0004_0005, 32'h0002_0009, 32'h0206_0402};
        exp_pc = '{32'd4, 32'd8, 32'd12};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(prog[i]);
            checks++;
            if (pc !== exp_pc[i] || pc !== m_pc) begin
                errors++;
                $display("[TB] FAIL load_add_pc%0d: got %08h expected %08h", i, pc, exp_pc[i]);
            end
        end
        checks++;
        if (dut.registerFile.registers[4] !== 8'd5 || dut.registerFile.registers[2] !== 8'd9 ||
            dut.registerFile.registers[6] !== 8'd14) begin
            errors++;
            $display("[TB] FAIL load_add_regs: got r4=%0d r2=%0d r6=%0d expected 5 9 14",
                     dut.registerFile.registers[4], dut.registerFile.registers[2],
                     dut.registerFile.registers[6]);
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] prog [4];
        int          dst [4];
        logic [7:0]  expv [4];
        prog = '{32'h0301_0402, 32'h0403_0402, 32'h0505_0402, 32'h0107_0006};
        dst  = '{1, 3, 5, 7};
        expv = '{8'hFC, 8'h01, 8'h0D, 8'd14};
        for (int i = 0; i < 4; i++) begin
            step(prog[i]);
            checks++;
            if (dut.registerFile.registers[dst[i]] !== expv[i] || expv[i] !== m_regs[dst[i]]) begin
                errors++;
                $display("[TB] FAIL alu_op%0d_r%0d: got %02h expected %02h", i, dst[i],
                         dut.registerFile.registers[dst[i]], expv[i]);
            end
        end
    endtask

    task automatic test_wrap();
        step(32'h0000_00FF);
        step(32'h0001_0001);
        step(32'h0202_0001);
        checks++;
        if (dut.registerFile.registers[2] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL wrap_add: got %02h expected 00", dut.registerFile.registers[2]);
        end
    endtask

    task automatic test_control_flow();
        logic [7:0] snap [8];
        do_reset();
        step(32'h0004_0005);
        step(32'h0002_0009);
        step(32'hFF00_0000);
        step(32'hFF00_0000);
        checks++;
        if (pc !== 32'd16) begin
            errors++;
            $display("[TB] FAIL cf_setup_pc: got %08h expected 00000010", pc);
        end
        step(32'h0602_0000);
        checks++;
        if (pc !== 32'd28) begin
            errors++;
            $display("[TB] FAIL jump_fwd: got %08h expected 0000001c", pc);
        end
        step(32'h07FE_0101);
        checks++;
        if (pc !== 32'd24) begin
            errors++;
            $display("[TB] FAIL beq_taken_back: got %08h expected 00000018", pc);
        end
        step(32'hFF00_0000);
        for (int i = 0; i < 8; i++) snap[i] = dut.registerFile.registers[i];
        step(32'h07FE_0402);
        checks++;
        if (pc !== 32'd32) begin
            errors++;
            $display("[TB] FAIL beq_not_taken: got %08h expected 00000020", pc);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.registerFile.registers[i] !== m_regs[i]) begin
                errors++;
                $display("[TB] FAIL branch_nowrite_r%0d: got %02h expected %02h", i,
                         dut.registerFile.registers[i], m_regs[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        int          bad;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            ins        = $urandom;
            ins[31:24] = 8'($urandom_range(0, 11));
            step(ins);
            bad = 0;
            checks++;
            if (pc !== m_pc) begin
                errors++;
                $display("[TB] FAIL random_pc #%0d ins=%08h: got %08h expected %08h", n, ins, pc, m_pc);
            end
            for (int i = 0; i < 8; i++) begin
                if (dut.registerFile.registers[i] !== m_regs[i]) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL random_regs #%0d ins=%08h: %0d registers differ (r0 got %02h expected %02h)",
                         n, ins, bad, dut.registerFile.registers[0], m_regs[0]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] prog [6];
        logic [31:0] trace_pc [6];
        logic [7:0]  trace_r [6];
        prog = '{32'h0000_0011, 32'h0001_0022, 32'h0202_0001,
                 32'h0303_0100, 32'h0604_0000, 32'h0507_0203};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(prog[i]);
            trace_pc[i] = pc;
            trace_r[i]  = dut.registerFile.registers[prog[i][18:16]];
        end
        do_reset();
        for (int i = 0; i < 3; i++) step(prog[i]);
        @(negedge clk);
        reset_n     = 1'b0;
        instruction = prog[3];
        @(posedge clk);
        model_reset();
        #1;
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_pc: got %08h expected 00000000", pc);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut.registerFile.registers[i] !== 8'h00) begin
                errors++;
                $display("[TB] FAIL midreset_r%0d: got %02h expected 00", i, dut.registerFile.registers[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            step(prog[i]);
            checks++;
            if (pc !== m_pc || pc !== trace_pc[i]) begin
                errors++;
                $display("[TB] FAIL rerun_pc%0d: got %08h expected %08h", i, pc, m_pc);
            end
            checks++;
            if (dut.registerFile.registers[prog[i][18:16]] !== m_regs[prog[i][18:16]] ||
                trace_r[i] !== m_regs[prog[i][18:16]]) begin
                errors++;
                $display("[TB] FAIL rerun_reg%0d: got %02h expected %02h", i,
                         dut.registerFile.registers[prog[i][18:16]], m_regs[prog[i][18:16]]);
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        instruction = 32'h0;
        model_reset();
        test_reset();
        test_load_add();
        test_alu_ops();
        test_wrap();
        test_control_flow();
        test_random();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
